// File: rtl/kyber_pkg.sv
// kyber_pkg
// Shared constants and types for the Kyber polynomial-arithmetic blocks.
//   KYBER_Q : modulus q = 3329
//   QINV    : q^-1 mod 2^16, as a signed 16-bit value (-3327)
//   MONT    : 2^16 mod q, signed representative (-1044)
//   WIDTH   : coefficient width
//   coeff_t : signed coefficient type
//   owner_t : id of the requester that issued a multiplier operation
package kyber_pkg;

  localparam int WIDTH = 16;
  localparam int KYBER_Q = 3329;
  localparam logic signed [WIDTH-1:0] QINV = -16'sd3327;
  localparam logic signed [WIDTH-1:0] MONT = -16'sd1044;

  typedef logic signed [WIDTH-1:0] coeff_t;

  typedef enum logic {
    OWNER_REQ0 = 1'b0,
    OWNER_REQ1 = 1'b1
  } owner_t;

endpackage

// File: rtl/mont_mul_arbiter_if.sv
// mont_mul_arbiter_if
// Requester/response bundle of the shared Montgomery multiplier.
//   req_valid[1:0] : per-requester operand valid
//   req_ready[1:0] : per-requester grant
//   req_a0/req_b0  : requester 0 operands (signed)
//   req_a1/req_b1  : requester 1 operands (signed)
//   rsp_valid[1:0] : one-cycle result strobe, one bit per requester
//   rsp_data       : signed result, valid while a rsp_valid bit is set
//   busy           : some pipeline stage holds a valid item
// Handshake: an operand pair transfers on a rising clk edge where
// req_valid[i] & req_ready[i]; req_ready[i] is never set without req_valid[i],
// and at most one ready bit is set. Responses have no backpressure: the
// requester must take rsp_data in the cycle its rsp_valid bit is high.
// modports: master = requester side, slave = arbiter side.
interface mont_mul_arbiter_if;
  import kyber_pkg::*;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  coeff_t     req_a0;
  coeff_t     req_b0;
  coeff_t     req_a1;
  coeff_t     req_b1;
  logic [1:0] rsp_valid;
  coeff_t     rsp_data;
  logic       busy;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1,
    output req_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/mont_mul_pipe.sv
// mont_mul_pipe
// Three-stage Montgomery multiplier with valid/owner sideband. Never stalls.
//   stage 1: register a, b, owner, valid
//   stage 2: p = a*b (32-bit signed)
//   stage 3: t = low16(p*QINV); r = (p - t*q) >>> 16, keep r[15:0]
// Result is congruent to a*b*2^-16 mod q, no final correction.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_owner    : item issued this cycle and who issued it
//   in_a, in_b           : signed operands
//   out_valid/out_owner  : stage-3 item and its owner
//   out_data             : stage-3 result (holds when out_valid is low)
//   busy                 : OR of the three stage valid bits
module mont_mul_pipe
  import kyber_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  owner_t in_owner,
  input  coeff_t in_a,
  input  coeff_t in_b,
  output logic   out_valid,
  output owner_t out_owner,
  output coeff_t out_data,
  output logic   busy
);

  logic               s1_valid;
  owner_t             s1_owner;
  coeff_t             s1_a;
  coeff_t             s1_b;
  logic               s2_valid;
  owner_t             s2_owner;
  logic signed [31:0] s2_p;
  logic               s3_valid;
  owner_t             s3_owner;
  coeff_t             s3_r;

  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;
  coeff_t             t;
  logic signed [31:0] t_ext;
  logic signed [31:0] diff;

  always_comb begin
    a_ext = 32'(s1_a);
    b_ext = 32'(s1_b);
    // Only the low 16 bits of p*QINV matter, so multiply the low halves.
    t     = s2_p[15:0] * QINV;
    t_ext = 32'(t);
    // Low 16 bits of diff are zero by construction of t.
    diff  = s2_p - t_ext * KYBER_Q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_owner <= OWNER_REQ0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_owner <= OWNER_REQ0;
      s2_p     <= '0;
      s3_valid <= 1'b0;
      s3_owner <= OWNER_REQ0;
      s3_r     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_owner <= in_owner;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s2_valid <= s1_valid;
      s2_owner <= s1_owner;
      s2_p     <= a_ext * b_ext;
      s3_valid <= s2_valid;
      s3_owner <= s2_owner;
      // Output register only loads on a valid item so rsp_data holds.
      if (s2_valid) s3_r <= 16'(diff >>> 16);
    end
  end

  assign out_valid = s3_valid;
  assign out_owner = s3_owner;
  assign out_data  = s3_r;
  assign busy      = s1_valid | s2_valid | s3_valid;

endmodule

// File: rtl/mont_mul_arbiter.sv
// mont_mul_arbiter
// Shares one mont_mul_pipe between two requesters: grants one operand pair
// per cycle, carries the owner id down the pipe and strobes the owner's
// rsp_valid bit three cycles after the transfer.
// Build option MONT_ARB_RR_EN:
//   defined     : round-robin, under contention the requester not granted on
//                 the most recent transfer wins (requester 0 first after reset)
//   not defined : fixed priority, requester 0 always wins contention
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset; discards in-flight items
//   bus  : mont_mul_arbiter_if.slave (requests, grants, responses, busy)
module mont_mul_arbiter
  import kyber_pkg::*;
(
  input logic               clk,
  input logic               rst,
  mont_mul_arbiter_if.slave bus
);

  logic [1:0] grant;
  logic       xfer;
  owner_t     grant_owner;
  coeff_t     sel_a;
  coeff_t     sel_b;
  logic       out_valid;
  owner_t     out_owner;
  coeff_t     out_data;
  logic       pipe_busy;

`ifdef MONT_ARB_RR_EN
  // Owner of the most recent transfer; reset value makes requester 0 win
  // the first contention.
  owner_t last_grant;

  always_comb begin
    grant = 2'b00;
    if (bus.req_valid == 2'b11) begin
      grant = (last_grant == OWNER_REQ0) ? 2'b10 : 2'b01;
    end else begin
      grant = bus.req_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= OWNER_REQ1;
    end else if (xfer) begin
      last_grant <= grant_owner;
    end
  end
`else
  always_comb begin
    grant    = 2'b00;
    grant[0] = bus.req_valid[0];
    grant[1] = bus.req_valid[1] & ~bus.req_valid[0];
  end
`endif

  // grant is a subset of req_valid, so any grant bit is a transfer.
  assign xfer        = |grant;
  assign grant_owner = grant[1] ? OWNER_REQ1 : OWNER_REQ0;
  assign sel_a       = grant[1] ? bus.req_a1 : bus.req_a0;
  assign sel_b       = grant[1] ? bus.req_b1 : bus.req_b0;

  mont_mul_pipe u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (xfer),
    .in_owner  (grant_owner),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .out_valid (out_valid),
    .out_owner (out_owner),
    .out_data  (out_data),
    .busy      (pipe_busy)
  );

  assign bus.req_ready    = grant;
  assign bus.rsp_valid[0] = out_valid & (out_owner == OWNER_REQ0);
  assign bus.rsp_valid[1] = out_valid & (out_owner == OWNER_REQ1);
  assign bus.rsp_data     = out_data;
  assign bus.busy         = pipe_busy;

endmodule
